// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial add sequencer built around one full-adder cell and
//               one carry flop. Operands are captured on an accepted start,
//               fed LSB-first through the adder one bit per clock, and the
//               assembled result is published with a one-cycle done strobe.
//               Used by the stopwatch datapath for time accumulate and lap
//               delta without a WIDTH-bit ripple adder.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   operand/result width in bits, 1..32 (default 8)
// Ports
//   clk     in   1      system clock, rising edge
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request; accepted only in IDLE or DONE
//   a       in   WIDTH  operand A, captured on accepted start
//   b       in   WIDTH  operand B, captured on accepted start
//   ci      in   1      carry-in, captured on accepted start
//   sub     in   1      (SERIAL_SUB_EN only) 1 = compute a - b
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle strobe, sum/co just updated
//   sum     out  WIDTH  result register, held until next completion
//   co      out  1      final carry-out (no-borrow when subtracting)
// Configuration
//   SERIAL_SUB_EN  when defined, adds the sub port and the subtract path.
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int              CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_last;
    logic             w_s_bit;
    logic             w_c_bit;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_ci_load;

    // Operand conditioning at load time: subtraction is a + ~b + 1.
`ifdef SERIAL_SUB_EN
    assign w_b_load  = sub ? ~b : b;
    assign w_ci_load = sub ? 1'b1 : ci;
`else
    assign w_b_load  = b;
    assign w_ci_load = ci;
`endif

    // start is only honoured when not mid-operation; DONE allows back-to-back.
    assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last = (r_state == ST_RUN) && (r_cnt == C_LAST);

    // The single full-adder cell.
    assign w_s_bit = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c_bit = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));

    // Result shift register fills from the MSB so that after WIDTH shifts the
    // first (LSB) sum bit has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_s_bit;
        end else begin : g_res_wn
            assign w_res_next = {w_s_bit, r_res[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == C_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            co      <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_ci_load;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_c_bit;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_res   <= w_res_next;
            // Outputs only ever change here, so partial sums stay hidden.
            if (w_last) begin
                sum <= w_res_next;
                co  <= w_c_bit;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire
